// File: rtl/apu_ch1_pkg.sv
// ============================================================================
// Module   : apu_ch1_pkg
// Purpose  : Shared constants and NR10 field layout for sound channel 1.
// Revision : 1.0
// ============================================================================
`default_nettype none

package apu_ch1_pkg;

   localparam logic [10:0] FREQ_MAX = 11'd2047;

   typedef struct packed {
      logic [2:0] period;
      logic       neg;
      logic [2:0] shift;
   } ch1_sweep_cfg_t;

endpackage

`default_nettype wire

// File: rtl/ch1_period_timer.sv
// ============================================================================
// Module   : ch1_period_timer
// Purpose  : Channel-1 period up-counter; pulses duty_clk_o once per period.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ch1_period_timer
   import apu_ch1_pkg::*;
#(
   parameter int FREQ_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_i,
   input  logic              reload_i,
   input  logic [FREQ_W-1:0] freq_i,
   output logic              duty_clk_o
);

   localparam logic [FREQ_W-1:0] c_TMR_TOP = FREQ_W'(FREQ_MAX);

   logic [FREQ_W-1:0] tmr_q;
   logic [FREQ_W-1:0] tmr_d;
   logic              duty_q;
   logic              duty_d;

   // A trigger reload takes precedence over a coincident tick and suppresses the pulse.
   always_comb begin
      tmr_d  = tmr_q;
      duty_d = 1'b0;
      if (reload_i) begin
         tmr_d = freq_i;
      end else if (tick_i) begin
         if (tmr_q == c_TMR_TOP) begin
            tmr_d  = freq_i;
            duty_d = 1'b1;
         end else begin
            tmr_d = tmr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_q  <= '0;
         duty_q <= 1'b0;
      end else begin
         tmr_q  <= tmr_d;
         duty_q <= duty_d;
      end
   end

   assign duty_clk_o = duty_q;

endmodule

`default_nettype wire

// File: rtl/ch1_sweep_freq.sv
// ============================================================================
// Module   : ch1_sweep_freq
// Purpose  : Channel-1 frequency register, NR10 sweep unit and period timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ch1_sweep_freq
   import apu_ch1_pkg::*;
#(
   parameter int FREQ_W      = 11,
   parameter int SWEEP_CTR_W = 3
) (
   input  logic              clk,
   input  logic              apu_reset,
   input  logic              tick_1mhz,
   input  logic              tick_128hz,
   input  logic [7:0]        d,
   input  logic              wr_ff10,
   input  logic              wr_ff13,
   input  logic              wr_ff14,
   input  logic              ch1_restart,
   output logic [FREQ_W-1:0] ch1_freq,
   output logic              ch1_duty_clk,
   output logic              ch1_sweep_ovf
);

   localparam int                  c_SCTR_W    = SWEEP_CTR_W + 1;
   localparam logic [c_SCTR_W-1:0] c_SCTR_DFLT = c_SCTR_W'(2 ** SWEEP_CTR_W);
   localparam logic [c_SCTR_W-1:0] c_SCTR_ONE  = c_SCTR_W'(1);

   ch1_sweep_cfg_t    cfg_q,     cfg_d;
   logic [FREQ_W-1:0] freq_q,    freq_d;
   logic [FREQ_W-1:0] shadow_q,  shadow_d;
   logic [c_SCTR_W-1:0] sctr_q,  sctr_d;
   logic              en_q,      en_d;
   logic              ovf_q,     ovf_d;
   logic              recheck_q, recheck_d;

   logic [FREQ_W:0]   w_calc_freq;
   logic [FREQ_W:0]   w_calc_shd;
   logic              w_ovf_freq;
   logic              w_ovf_shd;
   logic [c_SCTR_W-1:0] w_sctr_reload;
   logic              w_step;

   function automatic logic [FREQ_W:0] f_calc(input logic [FREQ_W-1:0] src,
                                              input ch1_sweep_cfg_t    cfg);
      logic [FREQ_W:0] base;
      logic [FREQ_W:0] delta;
      base  = {1'b0, src};
      delta = base >> cfg.shift;
      return cfg.neg ? (base - delta) : (base + delta);
   endfunction

   // Carry out of the 11-bit range is exactly "next > 2047" for additive sweeps.
   assign w_calc_freq   = f_calc(freq_q, cfg_q);
   assign w_calc_shd    = f_calc(shadow_q, cfg_q);
   assign w_ovf_freq    = !cfg_q.neg && w_calc_freq[FREQ_W];
   assign w_ovf_shd     = !cfg_q.neg && w_calc_shd[FREQ_W];
   assign w_sctr_reload = (cfg_q.period == 3'd0) ? c_SCTR_DFLT : c_SCTR_W'(cfg_q.period);

   always_comb begin
      cfg_d     = cfg_q;
      freq_d    = freq_q;
      shadow_d  = shadow_q;
      sctr_d    = sctr_q;
      en_d      = en_q;
      ovf_d     = ovf_q;
      recheck_d = 1'b0;
      w_step    = 1'b0;

      if (ch1_restart) begin
         shadow_d = freq_q;
         sctr_d   = w_sctr_reload;
         en_d     = (cfg_q.period != 3'd0) || (cfg_q.shift != 3'd0);
         ovf_d    = (cfg_q.shift != 3'd0) && w_ovf_freq;
      end else begin
         if (recheck_q && w_ovf_shd) begin
            ovf_d = 1'b1;
         end
         if (tick_128hz) begin
            if (sctr_q <= c_SCTR_ONE) begin
               sctr_d = w_sctr_reload;
               w_step = 1'b1;
            end else begin
               sctr_d = sctr_q - 1'b1;
            end
         end
         if (w_step && en_q && (cfg_q.period != 3'd0) && !ovf_q) begin
            if (w_ovf_shd) begin
               ovf_d = 1'b1;
            end else if (cfg_q.shift != 3'd0) begin
               freq_d    = w_calc_shd[FREQ_W-1:0];
               shadow_d  = w_calc_shd[FREQ_W-1:0];
               recheck_d = 1'b1;
            end
         end
      end

      // CPU bytes overlay whatever the sweep produced in the same cycle.
      if (wr_ff13) begin
         freq_d[7:0] = d;
      end
      if (wr_ff14) begin
         freq_d[FREQ_W-1:8] = d[FREQ_W-9:0];
      end
      if (wr_ff10) begin
         cfg_d = d[6:0];
      end
   end

   always_ff @(posedge clk) begin
      if (apu_reset) begin
         cfg_q     <= '0;
         freq_q    <= '0;
         shadow_q  <= '0;
         sctr_q    <= '0;
         en_q      <= 1'b0;
         ovf_q     <= 1'b0;
         recheck_q <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         freq_q    <= freq_d;
         shadow_q  <= shadow_d;
         sctr_q    <= sctr_d;
         en_q      <= en_d;
         ovf_q     <= ovf_d;
         recheck_q <= recheck_d;
      end
   end

   ch1_period_timer #(
      .FREQ_W (FREQ_W)
   ) u_timer (
      .clk        (clk),
      .rst        (apu_reset),
      .tick_i     (tick_1mhz),
      .reload_i   (ch1_restart),
      .freq_i     (freq_q),
      .duty_clk_o (ch1_duty_clk)
   );

   assign ch1_freq      = freq_q;
   assign ch1_sweep_ovf = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ch1_sweep_freq.sv
// ============================================================================
// Module   : tb_ch1_sweep_freq
// Purpose  : Self-checking bench for ch1_sweep_freq with a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ch1_sweep_freq;

   logic        clk = 1'b0;
   logic        apu_reset = 1'b1;
   logic        tick_1mhz = 1'b0;
   logic        tick_128hz = 1'b0;
   logic [7:0]  d = 8'h00;
   logic        wr_ff10 = 1'b0;
   logic        wr_ff13 = 1'b0;
   logic        wr_ff14 = 1'b0;
   logic        ch1_restart = 1'b0;
   logic [10:0] ch1_freq;
   logic        ch1_duty_clk;
   logic        ch1_sweep_ovf;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: timer tracked as "ticks remaining until next pulse".
   int m_freq, m_shadow, m_left, m_sctr, m_duty, m_ovf, m_pend, m_en;
   int m_per, m_neg, m_shift;

   always #5 clk = ~clk;

   ch1_sweep_freq dut (
      .clk           (clk),
      .apu_reset     (apu_reset),
      .tick_1mhz     (tick_1mhz),
      .tick_128hz    (tick_128hz),
      .d             (d),
      .wr_ff10       (wr_ff10),
      .wr_ff13       (wr_ff13),
      .wr_ff14       (wr_ff14),
      .ch1_restart   (ch1_restart),
      .ch1_freq      (ch1_freq),
      .ch1_duty_clk  (ch1_duty_clk),
      .ch1_sweep_ovf (ch1_sweep_ovf)
   );

   function automatic int calc(input int s);
      int dl;
      dl = s >> m_shift;
      return (m_neg != 0) ? s - dl : s + dl;
   endfunction

   function automatic bit too_big(input int s);
      return (m_neg == 0) && (calc(s) > 2047);
   endfunction

   function automatic void model_edge();
      int f, sh, sc, ov, pd, du, lf, en, nx;
      bit fire;
      if (apu_reset) begin
         m_freq = 0; m_shadow = 0; m_left = 2048; m_sctr = 0; m_duty = 0;
         m_ovf = 0; m_pend = 0; m_en = 0; m_per = 0; m_neg = 0; m_shift = 0;
         return;
      end
      f = m_freq; sh = m_shadow; sc = m_sctr; ov = m_ovf; en = m_en;
      pd = 0; du = 0; lf = m_left;
      if (ch1_restart) lf = 2048 - m_freq;
      else if (tick_1mhz) begin
         if (m_left == 1) begin du = 1; lf = 2048 - m_freq; end
         else lf = m_left - 1;
      end
      if (ch1_restart) begin
         sh = m_freq;
         sc = (m_per == 0) ? 8 : m_per;
         en = (m_per != 0 || m_shift != 0) ? 1 : 0;
         ov = (m_shift != 0 && too_big(m_freq)) ? 1 : 0;
      end else begin
         if (m_pend != 0 && too_big(m_shadow)) ov = 1;
         if (tick_128hz) begin
            fire = (m_sctr <= 1);
            sc = fire ? ((m_per == 0) ? 8 : m_per) : m_sctr - 1;
            if (fire && m_en != 0 && m_per != 0 && m_ovf == 0) begin
               nx = calc(m_shadow);
               if (too_big(m_shadow)) ov = 1;
               else if (m_shift != 0) begin f = nx; sh = nx; pd = 1; end
            end
         end
      end
      if (wr_ff13) f = (f & 'h700) | int'(d);
      if (wr_ff14) f = (f & 'hFF) | (int'(d & 8'h07) << 8);
      if (wr_ff10) begin
         m_per = (d >> 4) & 7; m_neg = (d >> 3) & 1; m_shift = d & 7;
      end
      m_freq = f; m_shadow = sh; m_sctr = sc; m_ovf = ov; m_en = en;
      m_pend = pd; m_duty = du; m_left = lf;
   endfunction

   task automatic cyc(input bit r, input bit rs, input bit t1, input bit t128,
                      input bit w10, input bit w13, input bit w14, input logic [7:0] dv);
      apu_reset = r; ch1_restart = rs; tick_1mhz = t1; tick_128hz = t128;
      wr_ff10 = w10; wr_ff13 = w13; wr_ff14 = w14; d = dv;
      @(posedge clk);
      model_edge();
      #1;
      apu_reset = 1'b0; ch1_restart = 1'b0; tick_1mhz = 1'b0; tick_128hz = 1'b0;
      wr_ff10 = 1'b0; wr_ff13 = 1'b0; wr_ff14 = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic setup(input logic [7:0] nr10, input logic [10:0] fr);
      cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 0, 1, 0, 0, nr10);
      cyc(0, 0, 0, 0, 0, 1, 0, fr[7:0]);
      cyc(0, 0, 0, 0, 0, 0, 1, {5'd0, fr[10:8]});
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_freq !== 11'h000) begin n_err++; $display("FAIL reset_freq got %h want 000", ch1_freq); end
      n_vec++; if (ch1_duty_clk !== 1'b0) begin n_err++; $display("FAIL reset_duty got %b want 0", ch1_duty_clk); end
      n_vec++; if (ch1_sweep_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ch1_sweep_ovf); end
   endtask

   task automatic test_timer();
      int pulses, first;
      setup(8'h00, 11'd2046);
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      for (int k = 1; k <= 12; k++) begin
         cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
         n_vec++;
         if (ch1_duty_clk !== ((k % 2) == 0) || int'(ch1_duty_clk) != m_duty) begin
            n_err++; $display("FAIL timer_2046 tick %0d got %b want %b", k, ch1_duty_clk, (k % 2) == 0);
         end
      end
      setup(8'h00, 11'd0);
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      pulses = 0; first = 0;
      for (int k = 1; k <= 4100; k++) begin
         cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
         if (ch1_duty_clk === 1'b1) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      n_vec++; if (pulses != 2) begin n_err++; $display("FAIL timer_0_count got %0d want 2", pulses); end
      n_vec++; if (first != 2048) begin n_err++; $display("FAIL timer_0_first got %0d want 2048", first); end
   endtask

   task automatic test_sweep_add();
      setup(8'h11, 11'h400);
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_sweep_ovf !== 1'b0) begin n_err++; $display("FAIL add_trig_ovf got %b want 0", ch1_sweep_ovf); end
      cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_freq !== 11'h600) begin n_err++; $display("FAIL add_step1_freq got %h want 600", ch1_freq); end
      n_vec++; if (ch1_sweep_ovf !== 1'b0) begin n_err++; $display("FAIL add_step1_ovf got %b want 0", ch1_sweep_ovf); end
      idle(1);
      n_vec++; if (ch1_sweep_ovf !== 1'b1) begin n_err++; $display("FAIL add_recheck_ovf got %b want 1", ch1_sweep_ovf); end
      cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
      idle(2);
      n_vec++; if (ch1_freq !== 11'h600) begin n_err++; $display("FAIL add_step2_freq got %h want 600", ch1_freq); end
      n_vec++; if (ch1_sweep_ovf !== 1'b1) begin n_err++; $display("FAIL add_step2_ovf got %b want 1", ch1_sweep_ovf); end
   endtask

   task automatic test_sweep_sub();
      setup(8'h19, 11'h400);
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_freq !== 11'h200) begin n_err++; $display("FAIL sub_step1_freq got %h want 200", ch1_freq); end
      idle(2);
      cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_freq !== 11'h100) begin n_err++; $display("FAIL sub_step2_freq got %h want 100", ch1_freq); end
      idle(2);
      n_vec++; if (ch1_sweep_ovf !== 1'b0) begin n_err++; $display("FAIL sub_ovf got %b want 0", ch1_sweep_ovf); end
   endtask

   task automatic test_immediate_ovf();
      setup(8'h01, 11'h7FF);
      n_vec++; if (ch1_sweep_ovf !== 1'b0) begin n_err++; $display("FAIL imm_pre_ovf got %b want 0", ch1_sweep_ovf); end
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_sweep_ovf !== 1'b1) begin n_err++; $display("FAIL imm_trig_ovf got %b want 1", ch1_sweep_ovf); end
      cyc(0, 0, 0, 0, 1, 0, 0, 8'h00);
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_sweep_ovf !== 1'b0) begin n_err++; $display("FAIL imm_retrig_ovf got %b want 0", ch1_sweep_ovf); end
   endtask

   task automatic test_period0();
      setup(8'h02, 11'h100);
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      for (int k = 0; k < 16; k++) begin
         cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
         idle(1);
         n_vec++;
         if (ch1_freq !== 11'h100 || ch1_sweep_ovf !== 1'b0) begin
            n_err++; $display("FAIL period0 step %0d got freq %h ovf %b want 100/0", k, ch1_freq, ch1_sweep_ovf);
         end
      end
   endtask

   task automatic test_collisions();
      setup(8'h11, 11'h400);
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 1, 0, 1, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_freq !== 11'h400) begin n_err++; $display("FAIL trig_tick_freq got %h want 400", ch1_freq); end
      cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_freq !== 11'h600) begin n_err++; $display("FAIL after_trig_tick_freq got %h want 600", ch1_freq); end
      cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
      n_vec++;
      if (ch1_freq !== 11'h000 || ch1_sweep_ovf !== 1'b0 || ch1_duty_clk !== 1'b0) begin
         n_err++; $display("FAIL reset_recheck got %h/%b/%b want 000/0/0", ch1_freq, ch1_sweep_ovf, ch1_duty_clk);
      end
      idle(1);
      n_vec++; if (ch1_sweep_ovf !== 1'b0) begin n_err++; $display("FAIL reset_recheck_late got %b want 0", ch1_sweep_ovf); end

      setup(8'h11, 11'h100);
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 1, 0, 1, 0, 8'h55);
      n_vec++; if (ch1_freq !== 11'h155) begin n_err++; $display("FAIL cpu_sweep_freq got %h want 155", ch1_freq); end
      idle(2);
      cyc(0, 0, 0, 1, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_freq !== 11'h240) begin n_err++; $display("FAIL cpu_sweep_shadow got %h want 240", ch1_freq); end

      setup(8'h00, 11'd2046);
      cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
      cyc(1, 0, 1, 0, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_duty_clk !== 1'b0) begin n_err++; $display("FAIL reset_mid_period got %b want 0", ch1_duty_clk); end
      cyc(0, 1, 1, 0, 0, 0, 0, 8'h00);
      n_vec++; if (ch1_duty_clk !== 1'b0) begin n_err++; $display("FAIL trig_tick1m got %b want 0", ch1_duty_clk); end
   endtask

   task automatic test_random();
      bit r, rs, t1, t128, w10, w13, w14;
      logic [7:0] dv;
      cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
      for (int k = 0; k < 3000; k++) begin
         r    = ($urandom_range(0, 299) == 0);
         rs   = ($urandom_range(0, 39) == 0);
         t1   = ($urandom_range(0, 1) == 0);
         t128 = ($urandom_range(0, 5) == 0);
         w10  = ($urandom_range(0, 49) == 0);
         w13  = ($urandom_range(0, 29) == 0);
         w14  = ($urandom_range(0, 29) == 0);
         dv   = 8'($urandom);
         cyc(r, rs, t1, t128, w10, w13, w14, dv);
         n_vec++;
         if (int'(ch1_freq) != m_freq || int'(ch1_duty_clk) != m_duty || int'(ch1_sweep_ovf) != m_ovf) begin
            n_err++;
            $display("FAIL random cyc %0d got freq %h duty %b ovf %b want freq %h duty %0d ovf %0d",
                     k, ch1_freq, ch1_duty_clk, ch1_sweep_ovf, m_freq[10:0], m_duty, m_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_timer();
      test_sweep_add();
      test_sweep_sub();
      test_immediate_ovf();
      test_period0();
      test_collisions();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
